// File: rtl/tlb_op_ctrl_pkg.sv
// rtl/tlb_op_ctrl_pkg.sv - shared encodings for the TLB maintenance controller
package tlb_op_ctrl_pkg;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   localparam logic [4:0] INV_ALL0    = 5'd0;
   localparam logic [4:0] INV_ALL1    = 5'd1;
   localparam logic [4:0] INV_G1      = 5'd2;
   localparam logic [4:0] INV_G0      = 5'd3;
   localparam logic [4:0] INV_ASID    = 5'd4;
   localparam logic [4:0] INV_ASID_VA = 5'd5;
   localparam logic [4:0] INV_GA_VA   = 5'd6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_2M = 6'd21;

   // A 2M page compares only the upper 10 bits of the VPPN.
   function automatic logic va_hit(input logic [18:0] e_vppn, input logic [5:0] e_ps,
                                   input logic [18:0] vppn);
      return ((e_ps == PS_4K) && (e_vppn == vppn)) ||
             ((e_ps == PS_2M) && (e_vppn[18:9] == vppn[18:9]));
   endfunction

endpackage

// File: rtl/tlb_op_ctrl_inv_match.sv
// rtl/tlb_op_ctrl_inv_match.sv - combinational INVTLB entry match (module tlb_inv_match)
module tlb_inv_match
   import tlb_op_ctrl_pkg::*;
(
   input  logic [4:0]  i_inv_op,
   input  logic [9:0]  i_asid,
   input  logic [18:0] i_vppn,
   input  logic        i_g,
   input  logic [9:0]  i_e_asid,
   input  logic [18:0] i_e_vppn,
   input  logic [5:0]  i_e_ps,
   output logic        o_match
);

   logic w_asid_eq;
   logic w_va_hit;

   assign w_asid_eq = (i_asid == i_e_asid);
   assign w_va_hit  = va_hit(i_e_vppn, i_e_ps, i_vppn);

   always_comb begin
      o_match = 1'b0;
      case (i_inv_op)
         INV_ALL0, INV_ALL1: o_match = 1'b1;
         INV_G1:             o_match = i_g;
         INV_G0:             o_match = !i_g;
         INV_ASID:           o_match = !i_g && w_asid_eq;
         INV_ASID_VA:        o_match = !i_g && w_asid_eq && w_va_hit;
         INV_GA_VA:          o_match = (i_g || w_asid_eq) && w_va_hit;
         default:            o_match = 1'b0;
      endcase
   end

endmodule

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - WB-stage TLB op sequencer (WR/FILL/INVTLB scan)
// Build option TLB_FILL_RANDOM_EN selects an LFSR fill index instead of a counter.
module tlb_op_ctrl
   import tlb_op_ctrl_pkg::*;
#(
   parameter int TLBNUM = 16,
   parameter int IDXW   = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            req_valid,
   input  logic [2:0]      req_op,
   input  logic [4:0]      req_inv_op,
   input  logic [9:0]      req_asid,
   input  logic [31:0]     req_va,
   input  logic [31:0]     req_pc,
   output logic            req_ready,
   input  logic            flush,
   input  logic [IDXW-1:0] csr_tlbidx,
   output logic [IDXW-1:0] r_index,
   input  logic            r_e,
   input  logic            r_g,
   input  logic [9:0]      r_asid,
   input  logic [18:0]     r_vppn,
   input  logic [5:0]      r_ps,
   output logic            we,
   output logic [IDXW-1:0] w_index,
   output logic            w_clear,
   output logic            busy,
   output logic            done,
   output logic            refetch,
   output logic [31:0]     refetch_pc
);

   logic [1:0]      r_state;
   logic [IDXW-1:0] r_cnt;
   logic [IDXW-1:0] r_fill;
   logic [2:0]      r_op;
   logic [4:0]      r_inv_op;
   logic [9:0]      r_asid_q;
   logic [18:0]     r_vppn_q;
   logic [31:0]     r_pc;

   logic w_accept;
   logic w_scan;
   logic w_done;
   logic w_to_scan;
   logic w_last;
   logic w_match;
   logic w_unused;

   // Gating with resetn keeps every output low while reset is held.
   assign w_accept  = resetn && (r_state == ST_IDLE) && req_valid && !flush;
   assign w_scan    = (r_state == ST_SCAN);
   assign w_done    = (r_state == ST_DONE);
   assign w_to_scan = (req_op == OP_INV) && (req_inv_op <= INV_GA_VA);
   assign w_last    = (r_cnt == IDXW'(TLBNUM - 1));
   assign w_unused  = ^{req_va[12:0], r_op};

   tlb_inv_match u_match (
      .i_inv_op (r_inv_op),
      .i_asid   (r_asid_q),
      .i_vppn   (r_vppn_q),
      .i_g      (r_g),
      .i_e_asid (r_asid),
      .i_e_vppn (r_vppn),
      .i_e_ps   (r_ps),
      .o_match  (w_match)
   );

   always_comb begin
      req_ready  = w_accept;
      busy       = w_accept || w_scan;
      done       = w_done;
      refetch    = w_done;
      refetch_pc = w_done ? (r_pc + 32'd4) : 32'd0;
      r_index    = w_scan ? r_cnt : '0;
      we         = 1'b0;
      w_index    = '0;
      w_clear    = 1'b0;
      if (w_accept && (req_op == OP_WR)) begin
         we      = 1'b1;
         w_index = csr_tlbidx;
      end else if (w_accept && (req_op == OP_FILL)) begin
         we      = 1'b1;
         w_index = r_fill;
      end else if (w_scan && r_e && w_match) begin
         we      = 1'b1;
         w_index = r_cnt;
         w_clear = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_inv_op <= '0;
         r_asid_q <= '0;
         r_vppn_q <= '0;
         r_pc     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op     <= req_op;
                  r_inv_op <= req_inv_op;
                  r_asid_q <= req_asid;
                  r_vppn_q <= req_va[31:13];
                  r_pc     <= req_pc;
                  r_cnt    <= '0;
                  r_state  <= w_to_scan ? ST_SCAN : ST_DONE;
               end
            end
            ST_SCAN: begin
               r_cnt <= r_cnt + IDXW'(1);
               if (w_last) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Fill index free-runs every cycle, stalls included.
   always_ff @(posedge clk or negedge resetn) begin
`ifdef TLB_FILL_RANDOM_EN
      if (!resetn) begin
         r_fill <= IDXW'(1);
      end else begin
         r_fill <= {r_fill[0] ^ r_fill[1], r_fill[IDXW-1:1]};
      end
`else
      if (!resetn) begin
         r_fill <= '0;
      end else begin
         r_fill <= r_fill + IDXW'(1);
      end
`endif
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - randomized self-checking bench for tlb_op_ctrl
module tb_tlb_op_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [4:0]  req_inv_op;
   logic [9:0]  req_asid;
   logic [31:0] req_va;
   logic [31:0] req_pc;
   logic        req_ready;
   logic        flush;
   logic [3:0]  csr_tlbidx;
   logic [3:0]  r_index;
   logic        r_e, r_g;
   logic [9:0]  r_asid;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic        we;
   logic [3:0]  w_index;
   logic        w_clear;
   logic        busy, done, refetch;
   logic [31:0] refetch_pc;

   logic        tlb_e    [16];
   logic        tlb_g    [16];
   logic [9:0]  tlb_asid [16];
   logic [18:0] tlb_vppn [16];
   logic [5:0]  tlb_ps   [16];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt;
   int lfsr_seq [15] = '{1, 8, 4, 2, 9, 12, 6, 11, 5, 10, 13, 14, 15, 7, 3};
   int fill_tbl [3];
   logic [15:0] obs_mask;
   logic [3:0]  acc_idx;

   always #5 clk = ~clk;

   tlb_op_ctrl #(.TLBNUM(16), .IDXW(4)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
      .req_inv_op(req_inv_op), .req_asid(req_asid), .req_va(req_va), .req_pc(req_pc),
      .req_ready(req_ready), .flush(flush), .csr_tlbidx(csr_tlbidx),
      .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn),
      .r_ps(r_ps), .we(we), .w_index(w_index), .w_clear(w_clear), .busy(busy),
      .done(done), .refetch(refetch), .refetch_pc(refetch_pc)
   );

   // TLB storage model answering the read port
   assign r_e    = tlb_e[r_index];
   assign r_g    = tlb_g[r_index];
   assign r_asid = tlb_asid[r_index];
   assign r_vppn = tlb_vppn[r_index];
   assign r_ps   = tlb_ps[r_index];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc_cnt <= 0;
      else         cyc_cnt <= cyc_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic bit exp_hit(input int i, input int inv_op, input logic [9:0] asid,
                                  input logic [31:0] va);
      bit asid_ok, va_ok;
      if (!tlb_e[i]) return 1'b0;
      asid_ok = (tlb_asid[i] == asid);
      va_ok   = (tlb_ps[i] == 6'd12 && tlb_vppn[i] == va[31:13]) ||
                (tlb_ps[i] == 6'd21 && tlb_vppn[i][18:9] == va[31:22]);
      case (inv_op)
         0, 1:    return 1'b1;
         2:       return tlb_g[i];
         3:       return !tlb_g[i];
         4:       return !tlb_g[i] && asid_ok;
         5:       return !tlb_g[i] && asid_ok && va_ok;
         6:       return (tlb_g[i] || asid_ok) && va_ok;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int exp_fill(input int n);
`ifdef TLB_FILL_RANDOM_EN
      return lfsr_seq[n % 15];
`else
      return n % 16;
`endif
   endfunction

   task automatic rand_entry(input int i);
      tlb_e[i]    = 1'($urandom);
      tlb_g[i]    = 1'($urandom);
      tlb_asid[i] = 10'($urandom_range(0, 3));
      tlb_ps[i]   = $urandom_range(0, 1) ? 6'd12 : 6'd21;
      tlb_vppn[i] = {10'($urandom_range(0, 2)), 9'($urandom_range(0, 1))};
   endtask

   // Called just after a negedge; leaves the bench just after a negedge in IDLE.
   task automatic run_op(input logic [2:0] op, input logic [4:0] inv_op, input logic [9:0] asid,
                         input logic [31:0] va, input logic [31:0] pc, input logic [3:0] idx,
                         input bit force_flush, output logic [15:0] mask, output logic [3:0] widx);
      bit          scan;
      int          n;
      logic [15:0] exp_mask;
      int          fill_n;
      scan = (op == 3'd4) && (inv_op <= 5'd6);
      for (int i = 0; i < 16; i++) exp_mask[i] = scan && exp_hit(i, int'(inv_op), asid, va);
      fill_n = exp_fill(cyc_cnt);
      req_valid = 1'b1; req_op = op; req_inv_op = inv_op; req_asid = asid;
      req_va = va; req_pc = pc; csr_tlbidx = idx; flush = 1'b0;
      #1;
      widx = w_index;
      check("accept_ready", req_ready, 1);
      check("accept_busy", busy, 1);
      check("accept_done", done, 0);
      if (op == 3'd2) begin
         check("wr_we", we, 1); check("wr_index", w_index, idx); check("wr_clear", w_clear, 0);
      end else if (op == 3'd3) begin
         check("fill_we", we, 1); check("fill_index", w_index, fill_n); check("fill_clear", w_clear, 0);
      end else begin
         check("accept_no_we", we, 0);
      end
      mask = '0;
      n = scan ? 16 : 0;
      for (int c = 1; c <= n + 1; c++) begin
         @(posedge clk); @(negedge clk);
         req_valid  = 1'($urandom);
         req_op     = 3'($urandom);
         req_inv_op = 5'($urandom);
         csr_tlbidx = 4'($urandom);
         flush      = force_flush ? 1'b1 : 1'($urandom);
         #1;
         check("busy_ignore_ready", req_ready, 0);
         if (c <= n) begin
            check("scan_busy", busy, 1);
            check("scan_done", done, 0);
            check("scan_rindex", r_index, c - 1);
            check("scan_we", we, exp_mask[c-1]);
            if (we) begin
               mask[w_index] = 1'b1;
               check("scan_windex", w_index, c - 1);
               check("scan_clear", w_clear, 1);
            end
         end else begin
            check("done_pulse", done, 1);
            check("done_refetch", refetch, 1);
            check("done_pc", refetch_pc, pc + 32'd4);
            check("done_busy", busy, 0);
            check("done_we", we, 0);
         end
      end
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      #1;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
   endtask

   task automatic all_valid();
      for (int i = 0; i < 16; i++) begin
         rand_entry(i);
         tlb_e[i] = 1'b1;
      end
   endtask

   initial begin
`ifdef TLB_FILL_RANDOM_EN
      fill_tbl = '{8, 4, 2};
`else
      fill_tbl = '{1, 2, 3};
`endif
      for (int i = 0; i < 16; i++) rand_entry(i);
      resetn = 1'b0; req_valid = 1'b1; req_op = 3'd2; req_inv_op = '0; req_asid = '0;
      req_va = '0; req_pc = '0; flush = 1'b0; csr_tlbidx = 4'd5;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_ready", req_ready, 0);
      check("rst_we", we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_refetch_pc", refetch_pc, 0);
      req_valid = 1'b0;
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); @(negedge clk);

      // WR to index 5
      run_op(3'd2, 5'd0, 10'd0, 32'h0, 32'h1000_0000, 4'd5, 1'b0, obs_mask, acc_idx);
      check("wr_idx5", acc_idx, 5);

      // INVTLB op 0 over a fully valid TLB
      all_valid();
      run_op(3'd4, 5'd0, 10'd0, 32'h0, 32'h2000_0040, 4'd0, 1'b0, obs_mask, acc_idx);
      check("inv0_mask", obs_mask, 16'hffff);

      // INVTLB op 5, asid 3, va 0x00400000
      for (int i = 0; i < 16; i++) begin
         tlb_e[i] = 1'b0; tlb_g[i] = 1'b0; tlb_asid[i] = 10'd3; tlb_ps[i] = 6'd12; tlb_vppn[i] = 19'h00200;
      end
      tlb_e[0] = 1'b1;
      tlb_e[1] = 1'b1; tlb_g[1] = 1'b1;
      tlb_e[2] = 1'b1; tlb_asid[2] = 10'd4;
      tlb_e[3] = 1'b1; tlb_ps[3] = 6'd21; tlb_vppn[3] = {10'h001, 9'h1ab};
      tlb_e[4] = 1'b1; tlb_vppn[4] = 19'h00201;
      tlb_e[6] = 1'b1; tlb_ps[6] = 6'd21; tlb_vppn[6] = {10'h002, 9'h000};
      run_op(3'd4, 5'd5, 10'd3, 32'h0040_0000, 32'h0000_3000, 4'd0, 1'b0, obs_mask, acc_idx);
      check("inv5_mask", obs_mask, 16'h0009);

      // INVTLB op 7 is a no-op
      all_valid();
      run_op(3'd4, 5'd7, 10'd0, 32'h0, 32'h0000_0100, 4'd0, 1'b0, obs_mask, acc_idx);
      check("inv7_mask", obs_mask, 16'h0000);

      // flush blocks acceptance in IDLE
      req_valid = 1'b1; req_op = 3'd2; flush = 1'b1;
      #1;
      check("flush_ready", req_ready, 0);
      check("flush_we", we, 0);
      check("flush_busy", busy, 0);
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      #1;
      check("flush_no_done", done, 0);

      // flush held through a scan is ignored
      run_op(3'd4, 5'd1, 10'd0, 32'h0, 32'h0000_0200, 4'd0, 1'b1, obs_mask, acc_idx);
      check("flush_scan_mask", obs_mask, 16'hffff);

      // reset during scan at index 8
      all_valid();
      req_valid = 1'b1; req_op = 3'd4; req_inv_op = 5'd0; flush = 1'b0;
      #1;
      check("abort_accept", req_ready, 1);
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); @(negedge clk);
         req_valid = 1'b0;
      end
      #1;
      check("abort_rindex8", r_index, 8);
      check("abort_we_before", we, 1);
      resetn = 1'b0;
      #1;
      check("abort_we", we, 0);
      check("abort_busy", busy, 0);
      check("abort_rindex", r_index, 0);
      @(posedge clk); @(negedge clk);
      resetn = 1'b1;
      #1;
      check("abort_idle_busy", busy, 0);
      check("abort_idle_done", done, 0);
      @(posedge clk); @(negedge clk);
      run_op(3'd0, 5'd0, 10'd0, 32'h0, 32'h0000_0400, 4'd0, 1'b0, obs_mask, acc_idx);

      // FILL index sequence from a fresh reset
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         resetn = 1'b0; req_valid = 1'b1; req_op = 3'd3;
         #1;
         check("rst_fill_ready", req_ready, 0);
         check("rst_fill_we", we, 0);
         @(negedge clk);
         resetn = 1'b1; req_valid = 1'b0;
         repeat (k) @(posedge clk);
         @(negedge clk);
         run_op(3'd3, 5'd0, 10'd0, 32'h0, 32'h0000_0800, 4'd0, 1'b0, obs_mask, acc_idx);
         check("fill_seq", acc_idx, fill_tbl[k-1]);
      end

      // randomized ops against the model
      for (int t = 0; t < 40; t++) begin
         logic [2:0]  op;
         logic [4:0]  iop;
         logic [31:0] va;
         for (int i = 0; i < 16; i++) rand_entry(i);
         op  = $urandom_range(0, 1) ? 3'd4 : 3'($urandom);
         iop = 5'($urandom_range(0, 8));
         va  = {10'($urandom_range(0, 2)), 9'($urandom_range(0, 1)), 13'($urandom)};
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); @(negedge clk);
         end
         run_op(op, iop, 10'($urandom_range(0, 3)), va, $urandom, 4'($urandom), 1'b0,
                obs_mask, acc_idx);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameters: TLBNUM, 16, TLB entry count (power of two); IDXW, 4, log2(TLBNUM).
REQ-002 SHALL have these clock and reset ports; only one clock, and reset is asynchronous and active-low:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have these request ports from the WB stage:
- req_valid  in  1  TLB instruction in WB.
- req_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; others are reserved.
- req_inv_op  in  5  INVTLB op field.
- req_asid  in  10  rj[9:0].
- req_va  in  32  rk.
- req_pc  in  32  instruction PC.
- req_ready  out  1  request accepted this cycle.
REQ-004 SHALL have: flush  in  1  WB exception or ertn this cycle.
REQ-005 SHALL have: csr_tlbidx  in  IDXW  TLBIDX.index.
REQ-006 SHALL have these TLB read-port ports:
- r_index  out  IDXW.
- r_e, r_g  in  1.
- r_asid  in  10.
- r_vppn  in  19.
- r_ps  in  6.
REQ-007 SHALL have these TLB write-control ports:
- we  out  1.
- w_index  out  IDXW.
- w_clear  out  1  when 1, the write stores E=0 instead of the CSR image.
REQ-008 SHALL have these status ports:
- busy  out  1  stall IF..WB.
- done  out  1  one-cycle completion pulse.
- refetch  out  1.
- refetch_pc  out  32.

Function
REQ-009 SHALL implement states IDLE, SCAN and DONE.
REQ-010 IDLE SHALL accept a request, with req_ready=1 for one cycle, when req_valid=1 and flush=0.
REQ-011 With flush=1, the request SHALL NOT be accepted.
REQ-012 On accept, the block SHALL latch req_op, req_inv_op, req_asid, req_va[31:13] and req_pc.
REQ-013 WR SHALL be accepted as follows: the accept cycle drives we=1, w_index=csr_tlbidx and w_clear=0; the next state is DONE.
REQ-014 FILL SHALL behave as WR, but with w_index=fill_idx.
REQ-015 SRCH, RD, reserved ops, and INV with inv_op>6 SHALL go from IDLE to DONE with no write.
REQ-016 INV with inv_op<=6 SHALL go from IDLE to SCAN with the scan counter set to 0.
REQ-017 In each SCAN cycle the block SHALL drive r_index=counter and evaluate the match combinationally on the r_* inputs of that same cycle.
REQ-018 On a match with r_e=1, the block SHALL drive we=1, w_index=counter and w_clear=1 in that same cycle.
REQ-019 The counter SHALL increment each SCAN cycle, and the block SHALL leave SCAN for DONE after index TLBNUM-1 with no wrap.
REQ-020 Match rules, where va_hit is r_vppn==va[31:13] when r_ps==12 and r_vppn[18:9]==va[31:22] when r_ps==21:
- ops 0 and 1: all entries.
- op 2: r_g=1.
- op 3: r_g=0.
- op 4: r_g=0 and asid equal.
- op 5: r_g=0, asid equal and va_hit.
- op 6: (r_g=1 or asid equal) and va_hit.
REQ-021 DONE SHALL last one cycle, in which done=1, refetch=1 and refetch_pc=latched pc+4; it then returns to IDLE.
REQ-022 busy SHALL be 1 in the accept cycle and in SCAN, and 0 in IDLE (non-accept cycles) and in DONE.
REQ-023 Latency SHALL be: non-scan ops, DONE one cycle after accept; INV, DONE at accept+TLBNUM+1.
REQ-024 A flush in SCAN or DONE SHALL be ignored, because the operation is already committed.
REQ-025 req_valid in non-IDLE states SHALL be ignored, with req_ready=0.
REQ-026 fill_idx SHALL advance every cycle, including stalls.
REQ-027 Outside the write cycles in REQ-013, REQ-014 and REQ-018, we SHALL be 0.

Reset
REQ-028 On resetn low, asynchronously: state=IDLE, counter=0, fill_idx=0 (LFSR seed 4'b0001 when REQ-030 applies), latched fields=0.
REQ-029 All outputs SHALL be 0 during reset; reset during SCAN SHALL abandon the scan with no further writes.

Configuration
REQ-030 With TLB_FILL_RANDOM_EN defined, fill_idx SHALL be a maximal-length IDXW-bit LFSR; for IDXW=4 the polynomial is x^4+x^3+1.
REQ-031 Without TLB_FILL_RANDOM_EN, fill_idx SHALL be a free-running modulo-TLBNUM up-counter; all other behaviour is identical.

Structure
REQ-032 The shared package SHALL hold the TLB op encodings, the INVTLB op constants, the state encoding and the PS constants 12 and 21.
REQ-033 The match logic SHALL be one sub-module, tlb_inv_match, which is purely combinational; the LFSR/counter stays inline.

Verification
REQ-034 The bench SHALL cover these scenarios:
- WR with csr_tlbidx=5: accept cycle shows we=1, w_index=5, w_clear=0; done the next cycle; refetch_pc=req_pc+4.
- INV op 0, all 16 entries e=1: 16 consecutive we pulses, w_index 0..15 with w_clear=1; done at cycle 17; busy=1 in cycles 0..16.
- INV op 5, asid=3, va=0x00400000: only entries with g=0, asid=3 and ps=12 vppn=0x00200 are cleared; ps=21 entries match on vppn[18:9]=0x001.
- INV op 7: no we; done the cycle after accept.
- req_valid with flush=1: req_ready=0 and no we; a flush during SCAN does not stop the scan.
- resetn asserted mid-SCAN at index 8: we=0 immediately, state IDLE after release; FILL sequence from a fresh reset: w_index 1,2,3 with TLB_FILL_RANDOM_EN off, and 8,4,2 (LFSR order from seed 1) with it on.
